// File: rtl/psram_bist.sv
// PSRAM built-in self test: writes a generated pattern over a word range, reads it back and compares.
// Optional watchdog on controller waits is enabled with `define PSRAM_BIST_TIMEOUT_EN.
//
//   state  | meaning
//   IDLE   | waiting for start
//   INIT   | waiting for controller idle before first write
//   W_REQ  | issue write strobe
//   W_ACK  | hold write strobe until controller busy
//   W_END  | wait for write completion, then advance / switch to read / abort
//   R_REQ  | issue read strobe
//   R_ACK  | hold read strobe until controller busy
//   R_END  | wait for read data, compare, then advance / finish / abort
//   DONE   | one-cycle completion, latch pass
module psram_bist #(
   parameter int ADDR_W = 24,
   parameter int DATA_W = 16,
   parameter int ERR_W  = 16,
   parameter logic [DATA_W-1:0] LFSR_TAPS = DATA_W'(16'hB400)
`ifdef PSRAM_BIST_TIMEOUT_EN
   , parameter int TIMEOUT_CYC = 1023
`endif
) (
   input  logic              clk_i,
   input  logic              rstn_i,
   input  logic              i_start,
   input  logic              i_abort,
   input  logic [1:0]        i_mode,
   input  logic [ADDR_W-1:0] i_base_addr,
   input  logic [ADDR_W-1:0] i_length,
   input  logic [DATA_W-1:0] i_seed,
   output logic              o_mem_stb,
   output logic              o_mem_we,
   output logic [ADDR_W-1:0] o_mem_addr,
   output logic [DATA_W-1:0] o_mem_din,
   input  logic              i_mem_busy,
   input  logic [DATA_W-1:0] i_mem_dout,
   output logic              o_busy,
   output logic              o_done,
   output logic              o_pass,
   output logic [ERR_W-1:0]  o_err_count,
   output logic [ADDR_W-1:0] o_first_err_addr,
   output logic [DATA_W-1:0] o_first_err_exp,
   output logic [DATA_W-1:0] o_first_err_got,
   output logic [3:0]        o_state
`ifdef PSRAM_BIST_TIMEOUT_EN
   , output logic            o_timeout
`endif
);

   typedef enum logic [3:0] {
      S_IDLE  = 4'd0,
      S_INIT  = 4'd1,
      S_W_REQ = 4'd2,
      S_W_ACK = 4'd3,
      S_W_END = 4'd4,
      S_R_REQ = 4'd5,
      S_R_ACK = 4'd6,
      S_R_END = 4'd7,
      S_DONE  = 4'd8
   } state_t;

   state_t            state_q, state_nxt;
   logic [1:0]        mode_q;
   logic [ADDR_W-1:0] base_q, len_q, idx_q, cur_q;
   logic [DATA_W-1:0] seed_q, lfsr_q, lfsr_step, pattern;
   logic [ERR_W-1:0]  err_q;
   logic [ADDR_W-1:0] ferr_addr_q;
   logic [DATA_W-1:0] ferr_exp_q, ferr_got_q;
   logic              busy_q, pass_q, abort_q, aborted_q;
   logic              abort_now, is_last, mismatch;
   logic              go_abort, rewind, advance, cmp;
   logic              tmo;

   function automatic logic [DATA_W-1:0] seed_fix(input logic [DATA_W-1:0] s);
      return (s == '0) ? DATA_W'(1) : s;
   endfunction

   assign abort_now = abort_q | i_abort;
   assign is_last   = (idx_q == len_q - ADDR_W'(1));
   assign lfsr_step = {1'b0, lfsr_q[DATA_W-1:1]} ^ (lfsr_q[0] ? LFSR_TAPS : '0);
   assign mismatch  = (i_mem_dout != pattern);

   always_comb begin
      case (mode_q)
         2'd0:    pattern = seed_q;
         2'd1:    pattern = DATA_W'(cur_q) ^ seed_q;
         2'd2:    pattern = DATA_W'(1) << (idx_q % ADDR_W'(DATA_W));
         default: pattern = lfsr_q;
      endcase
   end

`ifdef PSRAM_BIST_TIMEOUT_EN
   localparam int WD_W = $clog2(TIMEOUT_CYC + 1);
   logic [WD_W-1:0] wd_q;
   logic            waiting, wd_hit, wd_clr, timeout_q;

   assign waiting = state_q inside {S_INIT, S_W_ACK, S_W_END, S_R_ACK, S_R_END};
   assign wd_hit  = waiting && (wd_q == WD_W'(TIMEOUT_CYC));
   assign wd_clr  = (state_nxt inside {S_INIT, S_W_REQ, S_R_REQ}) && (state_nxt != state_q);
   assign tmo     = timeout_q;
   assign o_timeout = timeout_q;

   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         wd_q      <= '0;
         timeout_q <= 1'b0;
      end else begin
         if (wd_clr)
            wd_q <= '0;
         else if (waiting)
            wd_q <= wd_q + WD_W'(1);
         if (state_q == S_IDLE && i_start)
            timeout_q <= 1'b0;
         else if (wd_hit)
            timeout_q <= 1'b1;
      end
   end
`else
   assign tmo = 1'b0;
`endif

   always_comb begin
      state_nxt = state_q;
      go_abort  = 1'b0;
      rewind    = 1'b0;
      advance   = 1'b0;
      cmp       = 1'b0;
      case (state_q)
         S_IDLE:  if (i_start) state_nxt = (i_length == '0) ? S_DONE : S_INIT;
         S_INIT:  if (!i_mem_busy) state_nxt = S_W_REQ;
         S_W_REQ: state_nxt = S_W_ACK;
         S_W_ACK: if (i_mem_busy) state_nxt = S_W_END;
         S_W_END: begin
            if (!i_mem_busy) begin
               if (abort_now) begin
                  go_abort  = 1'b1;
                  state_nxt = S_DONE;
               end else if (is_last) begin
                  rewind    = 1'b1;
                  state_nxt = S_R_REQ;
               end else begin
                  advance   = 1'b1;
                  state_nxt = S_W_REQ;
               end
            end
         end
         S_R_REQ: state_nxt = S_R_ACK;
         S_R_ACK: if (i_mem_busy) state_nxt = S_R_END;
         S_R_END: begin
            if (!i_mem_busy) begin
               cmp = 1'b1;
               if (abort_now) begin
                  go_abort  = 1'b1;
                  state_nxt = S_DONE;
               end else if (is_last) begin
                  state_nxt = S_DONE;
               end else begin
                  advance   = 1'b1;
                  state_nxt = S_R_REQ;
               end
            end
         end
         S_DONE:  state_nxt = S_IDLE;
         default: state_nxt = S_IDLE;
      endcase
`ifdef PSRAM_BIST_TIMEOUT_EN
      // A stuck controller overrides any pending transition.
      if (wd_hit) begin
         state_nxt = S_DONE;
         go_abort  = 1'b0;
         rewind    = 1'b0;
         advance   = 1'b0;
         cmp       = 1'b0;
      end
`endif
   end

   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         state_q     <= S_IDLE;
         mode_q      <= '0;
         base_q      <= '0;
         len_q       <= '0;
         seed_q      <= '0;
         idx_q       <= '0;
         cur_q       <= '0;
         lfsr_q      <= '0;
         err_q       <= '0;
         ferr_addr_q <= '0;
         ferr_exp_q  <= '0;
         ferr_got_q  <= '0;
         busy_q      <= 1'b0;
         pass_q      <= 1'b0;
         abort_q     <= 1'b0;
         aborted_q   <= 1'b0;
      end else begin
         state_q <= state_nxt;
         if (state_q == S_IDLE) begin
            if (i_start) begin
               mode_q      <= i_mode;
               base_q      <= i_base_addr;
               len_q       <= i_length;
               seed_q      <= i_seed;
               idx_q       <= '0;
               cur_q       <= i_base_addr;
               lfsr_q      <= seed_fix(i_seed);
               err_q       <= '0;
               ferr_addr_q <= '0;
               ferr_exp_q  <= '0;
               ferr_got_q  <= '0;
               busy_q      <= 1'b1;
               pass_q      <= 1'b0;
               abort_q     <= 1'b0;
               aborted_q   <= 1'b0;
            end
         end else begin
            if (i_abort)
               abort_q <= 1'b1;
            if (rewind) begin
               idx_q  <= '0;
               cur_q  <= base_q;
               lfsr_q <= seed_fix(seed_q);
            end
            if (advance) begin
               idx_q  <= idx_q + ADDR_W'(1);
               cur_q  <= cur_q + ADDR_W'(1);
               lfsr_q <= lfsr_step;
            end
            if (cmp && mismatch) begin
               if (err_q != '1)
                  err_q <= err_q + ERR_W'(1);
               if (err_q == '0) begin
                  ferr_addr_q <= cur_q;
                  ferr_exp_q  <= pattern;
                  ferr_got_q  <= i_mem_dout;
               end
            end
            if (go_abort)
               aborted_q <= 1'b1;
            if (state_q == S_DONE) begin
               busy_q <= 1'b0;
               pass_q <= (err_q == '0) && !aborted_q && !tmo;
            end
         end
      end
   end

   assign o_mem_stb        = state_q inside {S_W_REQ, S_W_ACK, S_R_REQ, S_R_ACK};
   assign o_mem_we         = state_q inside {S_W_REQ, S_W_ACK};
   assign o_mem_addr       = cur_q;
   assign o_mem_din        = o_mem_we ? pattern : '0;
   assign o_busy           = busy_q;
   assign o_done           = (state_q == S_DONE);
   assign o_pass           = pass_q;
   assign o_err_count      = err_q;
   assign o_first_err_addr = ferr_addr_q;
   assign o_first_err_exp  = ferr_exp_q;
   assign o_first_err_got  = ferr_got_q;
   assign o_state          = state_q;

endmodule

// File: tb/tb_psram_bist.sv
// Directed bench for psram_bist with a behavioural PSRAM controller model (busy for 3 cycles per access).
// Build with +define+PSRAM_BIST_TIMEOUT_EN to also exercise the watchdog with TIMEOUT_CYC=15.
module tb_psram_bist;

   logic        clk_i = 1'b0;
   logic        rstn_i = 1'b0;
   logic        i_start = 1'b0;
   logic        i_abort = 1'b0;
   logic [1:0]  i_mode = '0;
   logic [23:0] i_base_addr = '0;
   logic [23:0] i_length = '0;
   logic [15:0] i_seed = '0;
   logic        o_mem_stb, o_mem_we;
   logic [23:0] o_mem_addr;
   logic [15:0] o_mem_din;
   logic        i_mem_busy;
   logic [15:0] i_mem_dout;
   logic        o_busy, o_done, o_pass;
   logic [15:0] o_err_count;
   logic [23:0] o_first_err_addr;
   logic [15:0] o_first_err_exp, o_first_err_got;
   logic [3:0]  o_state;
`ifdef PSRAM_BIST_TIMEOUT_EN
   logic        o_timeout;
`endif

   psram_bist #(
      .ADDR_W(24), .DATA_W(16), .ERR_W(16)
`ifdef PSRAM_BIST_TIMEOUT_EN
      , .TIMEOUT_CYC(15)
`endif
   ) dut (
      .clk_i(clk_i), .rstn_i(rstn_i), .i_start(i_start), .i_abort(i_abort),
      .i_mode(i_mode), .i_base_addr(i_base_addr), .i_length(i_length), .i_seed(i_seed),
      .o_mem_stb(o_mem_stb), .o_mem_we(o_mem_we), .o_mem_addr(o_mem_addr), .o_mem_din(o_mem_din),
      .i_mem_busy(i_mem_busy), .i_mem_dout(i_mem_dout),
      .o_busy(o_busy), .o_done(o_done), .o_pass(o_pass), .o_err_count(o_err_count),
      .o_first_err_addr(o_first_err_addr), .o_first_err_exp(o_first_err_exp),
      .o_first_err_got(o_first_err_got), .o_state(o_state)
`ifdef PSRAM_BIST_TIMEOUT_EN
      , .o_timeout(o_timeout)
`endif
   );

   always #5 clk_i = ~clk_i;

   // Controller model and access log
   logic [15:0] mem [0:255];
   logic [23:0] wr_addr [0:63];
   logic [15:0] wr_data [0:63];
   logic [23:0] rd_addr [0:63];
   int          wr_cnt = 0, rd_cnt = 0, stb_cyc = 0, cyc = 0;
   logic [1:0]  cnt;
   logic        m_we;
   logic [23:0] m_addr;
   logic        stuck = 1'b0, corrupt = 1'b0;
   logic [23:0] cor_addr = '0;

   always @(posedge clk_i) begin
      cyc <= cyc + 1;
      if (o_mem_stb) stb_cyc <= stb_cyc + 1;
   end

   always @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         i_mem_busy <= 1'b0;
         i_mem_dout <= '0;
         cnt        <= '0;
         m_we       <= 1'b0;
         m_addr     <= '0;
      end else if (!i_mem_busy) begin
         if (o_mem_stb) begin
            i_mem_busy <= 1'b1;
            cnt        <= 2'd3;
            m_we       <= o_mem_we;
            m_addr     <= o_mem_addr;
            if (o_mem_we) begin
               mem[o_mem_addr[7:0]] <= o_mem_din;
               wr_addr[wr_cnt]      <= o_mem_addr;
               wr_data[wr_cnt]      <= o_mem_din;
               wr_cnt               <= wr_cnt + 1;
            end else begin
               rd_addr[rd_cnt] <= o_mem_addr;
               rd_cnt          <= rd_cnt + 1;
            end
         end
      end else if (!stuck) begin
         if (cnt == 2'd1) begin
            i_mem_busy <= 1'b0;
            if (!m_we)
               i_mem_dout <= (corrupt && m_addr == cor_addr) ? 16'hFFFF : mem[m_addr[7:0]];
         end else begin
            cnt <= cnt - 2'd1;
         end
      end
   end

   int n_chk = 0, n_fail = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic run_bist(input logic [1:0] mode, input logic [23:0] base, input logic [23:0] len,
                           input logic [15:0] seed, input int abort_at, input int w0, output int lat);
      bit sent = 0;
      @(negedge clk_i);
      i_mode = mode; i_base_addr = base; i_length = len; i_seed = seed; i_start = 1'b1;
      @(negedge clk_i);
      i_start = 1'b0;
      lat = 1;
      while (!o_done && lat < 3000) begin
         if (abort_at != 0 && !sent && wr_cnt == w0 + abort_at) begin
            i_abort = 1'b1;
            sent = 1;
         end else begin
            i_abort = 1'b0;
         end
         @(negedge clk_i);
         lat++;
      end
      i_abort = 1'b0;
      check("done_seen", {31'd0, o_done}, 32'd1);
   endtask

   initial begin
      int w0, r0, s0, lat, t0, t1;
      logic [15:0] lfsr_exp [0:3];
      lfsr_exp[0] = 16'hACE1; lfsr_exp[1] = 16'hE270; lfsr_exp[2] = 16'h7138; lfsr_exp[3] = 16'h389C;

      repeat (3) @(negedge clk_i);
      check("rst_state", {28'd0, o_state}, 32'd0);
      check("rst_stb", {31'd0, o_mem_stb}, 32'd0);
      check("rst_busy", {31'd0, o_busy}, 32'd0);
      rstn_i = 1'b1;
      repeat (2) @(negedge clk_i);

      // Address pattern, ideal memory
      w0 = wr_cnt; r0 = rd_cnt;
      run_bist(2'd1, 24'h000100, 24'd8, 16'h0000, 0, w0, lat);
      check("m1_busy_at_done", {31'd0, o_busy}, 32'd1);
      check("m1_wr_cnt", wr_cnt - w0, 8);
      check("m1_rd_cnt", rd_cnt - r0, 8);
      for (int i = 0; i < 8; i++) begin
         check("m1_wr_addr", wr_addr[w0+i], 32'h100 + i);
         check("m1_wr_data", wr_data[w0+i], 32'h100 + i);
         check("m1_rd_addr", rd_addr[r0+i], 32'h100 + i);
      end
      @(negedge clk_i);
      check("m1_done_pulse", {31'd0, o_done}, 32'd0);
      check("m1_pass", {31'd0, o_pass}, 32'd1);
      check("m1_err", o_err_count, 32'd0);
      check("m1_busy_after", {31'd0, o_busy}, 32'd0);

      // LFSR with one corrupted word
      corrupt = 1'b1; cor_addr = 24'h000102;
      w0 = wr_cnt;
      run_bist(2'd3, 24'h000100, 24'd4, 16'hACE1, 0, w0, lat);
      for (int i = 0; i < 4; i++) check("m3_wr_data", wr_data[w0+i], {16'd0, lfsr_exp[i]});
      @(negedge clk_i);
      corrupt = 1'b0;
      check("m3_err", o_err_count, 32'd1);
      check("m3_ferr_addr", o_first_err_addr, 32'h102);
      check("m3_ferr_exp", o_first_err_exp, 32'h7138);
      check("m3_ferr_got", o_first_err_got, 32'hFFFF);
      check("m3_pass", {31'd0, o_pass}, 32'd0);

      // Empty test
      w0 = wr_cnt; s0 = stb_cyc;
      run_bist(2'd0, 24'h000010, 24'd0, 16'h1234, 0, w0, lat);
      check("len0_latency_ok", {31'd0, lat <= 2}, 32'd1);
      @(negedge clk_i);
      check("len0_no_stb", stb_cyc - s0, 0);
      check("len0_pass", {31'd0, o_pass}, 32'd1);
      check("len0_err_clr", o_err_count, 32'd0);
      check("len0_ferr_clr", o_first_err_addr, 32'd0);

      // Range wrapping past the top of memory
      w0 = wr_cnt; r0 = rd_cnt;
      run_bist(2'd0, 24'hFFFFFE, 24'd4, 16'h5A5A, 0, w0, lat);
      check("wrap_wr0", wr_addr[w0+0], 32'hFFFFFE);
      check("wrap_wr1", wr_addr[w0+1], 32'hFFFFFF);
      check("wrap_wr2", wr_addr[w0+2], 32'h000000);
      check("wrap_wr3", wr_addr[w0+3], 32'h000001);
      check("wrap_rd2", rd_addr[r0+2], 32'h000000);
      check("wrap_data", wr_data[w0+3], 32'h5A5A);
      @(negedge clk_i);
      check("wrap_pass", {31'd0, o_pass}, 32'd1);

      // Walking one wraps every 16 words
      w0 = wr_cnt;
      run_bist(2'd2, 24'h000000, 24'd18, 16'h0000, 0, w0, lat);
      check("walk_0", wr_data[w0+0], 32'h0001);
      check("walk_15", wr_data[w0+15], 32'h8000);
      check("walk_16", wr_data[w0+16], 32'h0001);
      check("walk_17", wr_data[w0+17], 32'h0002);
      @(negedge clk_i);
      check("walk_pass", {31'd0, o_pass}, 32'd1);

      // Reset in the middle of a write handshake
      w0 = wr_cnt;
      @(negedge clk_i);
      i_mode = 2'd0; i_base_addr = 24'h000040; i_length = 24'd8; i_seed = 16'h00FF; i_start = 1'b1;
      @(negedge clk_i);
      i_start = 1'b0;
      for (int k = 0; k < 200 && wr_cnt < w0 + 2; k++) @(negedge clk_i);
      check("rmid_reached", {31'd0, wr_cnt >= w0 + 2}, 32'd1);
      check("rmid_busy_before", {31'd0, o_busy}, 32'd1);
      #2 rstn_i = 1'b0;
      #1;
      check("rmid_stb", {31'd0, o_mem_stb}, 32'd0);
      check("rmid_we", {31'd0, o_mem_we}, 32'd0);
      check("rmid_addr", o_mem_addr, 32'd0);
      check("rmid_busy", {31'd0, o_busy}, 32'd0);
      check("rmid_pass", {31'd0, o_pass}, 32'd0);
      check("rmid_state", {28'd0, o_state}, 32'd0);
      @(negedge clk_i);
      rstn_i = 1'b1;
      repeat (2) @(negedge clk_i);

      // Abort during the third write
      w0 = wr_cnt; r0 = rd_cnt;
      run_bist(2'd0, 24'h000020, 24'd8, 16'hC3C3, 3, w0, lat);
      check("abort_ctrl_idle", {31'd0, i_mem_busy}, 32'd0);
      check("abort_wr_cnt", wr_cnt - w0, 3);
      check("abort_rd_cnt", rd_cnt - r0, 0);
      @(negedge clk_i);
      check("abort_pass", {31'd0, o_pass}, 32'd0);
      check("abort_err", o_err_count, 32'd0);

`ifdef PSRAM_BIST_TIMEOUT_EN
      // Controller busy stuck high after the first write request
      stuck = 1'b1;
      @(negedge clk_i);
      i_mode = 2'd0; i_base_addr = 24'h000080; i_length = 24'd4; i_seed = 16'h1111; i_start = 1'b1;
      @(negedge clk_i);
      i_start = 1'b0;
      for (int k = 0; k < 200 && !i_mem_busy; k++) @(negedge clk_i);
      check("tmo_busy_stuck", {31'd0, i_mem_busy}, 32'd1);
      t0 = cyc;
      for (int k = 0; k < 200 && !o_done; k++) @(negedge clk_i);
      t1 = cyc;
      check("tmo_done", {31'd0, o_done}, 32'd1);
      check("tmo_latency_ok", {31'd0, (t1 - t0 >= 16) && (t1 - t0 <= 18)}, 32'd1);
      check("tmo_flag", {31'd0, o_timeout}, 32'd1);
      check("tmo_stb", {31'd0, o_mem_stb}, 32'd0);
      @(negedge clk_i);
      check("tmo_pass", {31'd0, o_pass}, 32'd0);
      check("tmo_held", {31'd0, o_timeout}, 32'd1);
      stuck = 1'b0;
      repeat (6) @(negedge clk_i);
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
